// File: rtl/div_ctrl.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU) with its own sequencer.
// Quotient/remainder and status flags are registered; results persist until the next completion.
module div_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             annul,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [WIDTH-1:0] prem, prem_d;
  logic [WIDTH-1:0] dvd, dvd_d;
  logic [WIDTH-1:0] dsr, dsr_d;
  logic             qneg, qneg_d;
  logic             rneg, rneg_d;
  logic             busy_d, valid_d;
  logic [WIDTH-1:0] quotient_d, remainder_d;

  logic [WIDTH:0]   shifted, diff;
  logic             borrow;
  logic [WIDTH-1:0] q_iter, r_iter;
  logic [WIDTH-1:0] a_mag, b_mag;

  // Next-state, datapath iteration and registered-output values
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    prem_d      = prem;
    dvd_d       = dvd;
    dsr_d       = dsr;
    qneg_d      = qneg;
    rneg_d      = rneg;
    quotient_d  = quotient;
    remainder_d = remainder;

    shifted = {prem, dvd[WIDTH-1]};
    diff    = shifted - {1'b0, dsr};
    borrow  = diff[WIDTH];
    q_iter  = WIDTH'({dvd, ~borrow});
    r_iter  = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];

    a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
    b_mag = (is_signed && b[WIDTH-1]) ? -b : b;

    case (state)
      DIV: begin
        prem_d = r_iter;
        dvd_d  = q_iter;
        cnt_d  = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          state_d     = DONE;
          quotient_d  = qneg ? -q_iter : q_iter;
          remainder_d = rneg ? -r_iter : r_iter;
        end
      end
      default: begin
        state_d = IDLE;
        if (start) begin
          if (b == '0) begin
            // Divide-by-zero bypasses the iteration loop entirely
            state_d     = DONE;
            quotient_d  = '1;
            remainder_d = a;
          end else begin
            state_d = DIV;
            cnt_d   = '0;
            prem_d  = '0;
            dvd_d   = a_mag;
            dsr_d   = b_mag;
            qneg_d  = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            rneg_d  = is_signed & a[WIDTH-1];
          end
        end
      end
    endcase

    // Flush overrides everything, including a completion in the same cycle
    if (annul) begin
      state_d     = IDLE;
      quotient_d  = quotient;
      remainder_d = remainder;
    end

    busy_d  = (state_d == DIV);
    valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      cnt          <= '0;
      prem         <= '0;
      dvd          <= '0;
      dsr          <= '0;
      qneg         <= 1'b0;
      rneg         <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      quotient     <= '0;
      remainder    <= '0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      prem         <= prem_d;
      dvd          <= dvd_d;
      dsr          <= dsr_d;
      qneg         <= qneg_d;
      rneg         <= rneg_d;
      busy         <= busy_d;
      result_valid <= valid_d;
      quotient     <= quotient_d;
      remainder    <= remainder_d;
    end
  end

endmodule
